// File: rtl/dccm_arb.sv
// LSU/DMA arbiter for a single-port DCCM with one-cycle read return.
// Optional DMA starvation override enabled by defining DCCM_ARB_STARVE_EN.
module dccm_arb #(
    parameter int unsigned STARVE_MAX = 4
) (
    input  logic        clk,
    input  logic        rst_n,

    input  logic        lsu_req_valid,
    output logic        lsu_req_ready,
    input  logic        lsu_req_we,
    input  logic [31:0] lsu_req_addr,
    input  logic [31:0] lsu_req_wdata,
    output logic        lsu_rsp_valid,
    output logic [31:0] lsu_rsp_rdata,

    input  logic        dma_req_valid,
    output logic        dma_req_ready,
    input  logic        dma_req_we,
    input  logic [31:0] dma_req_addr,
    input  logic [31:0] dma_req_wdata,
    output logic        dma_rsp_valid,
    output logic [31:0] dma_rsp_rdata,

    output logic        dccm_wren,
    output logic        dccm_rden,
    output logic [31:0] dccm_wr_addr,
    output logic [31:0] dccm_wr_data,
    input  logic [31:0] dccm_rd_data
);

    if (STARVE_MAX < 1 || STARVE_MAX > 15) begin : g_bad_param
        $error("dccm_arb: STARVE_MAX must be in 1..15");
    end

    logic gnt_lsu, gnt_dma, gnt_we;
    logic starve_hit;
    logic pend_q, pend_d;
    logic tag_q, tag_d;   // response owner: 1 = DMA, 0 = LSU

`ifdef DCCM_ARB_STARVE_EN
    logic [3:0] starve_q, starve_d;

    assign starve_hit = dma_req_valid && (starve_q >= 4'(STARVE_MAX));

    always_comb begin
        starve_d = '0;
        if (dma_req_valid && !gnt_dma)
            starve_d = (starve_q >= 4'(STARVE_MAX)) ? starve_q : starve_q + 4'd1;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) starve_q <= '0;
        else        starve_q <= starve_d;
    end
`else
    assign starve_hit = 1'b0;
`endif

    // Grants are suppressed during reset so nothing reaches the DCCM.
    always_comb begin
        gnt_lsu = 1'b0;
        gnt_dma = 1'b0;
        if (rst_n) begin
            if (lsu_req_valid && !starve_hit) gnt_lsu = 1'b1;
            else if (dma_req_valid)           gnt_dma = 1'b1;
        end
    end

    assign gnt_we        = (gnt_lsu && lsu_req_we) || (gnt_dma && dma_req_we);
    assign lsu_req_ready = gnt_lsu;
    assign dma_req_ready = gnt_dma;

    assign dccm_wren     = gnt_we;
    assign dccm_rden     = (gnt_lsu || gnt_dma) && !gnt_we;
    assign dccm_wr_addr  = gnt_lsu ? lsu_req_addr  : (gnt_dma ? dma_req_addr  : 32'h0);
    assign dccm_wr_data  = gnt_lsu ? lsu_req_wdata : (gnt_dma ? dma_req_wdata : 32'h0);

    assign pend_d = dccm_rden;
    assign tag_d  = gnt_dma;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            pend_q <= 1'b0;
            tag_q  <= 1'b0;
        end else begin
            pend_q <= pend_d;
            tag_q  <= tag_d;
        end
    end

    assign lsu_rsp_valid = rst_n && pend_q && !tag_q;
    assign dma_rsp_valid = rst_n && pend_q &&  tag_q;
    assign lsu_rsp_rdata = lsu_rsp_valid ? dccm_rd_data : 32'h0;
    assign dma_rsp_rdata = dma_rsp_valid ? dccm_rd_data : 32'h0;

endmodule

// File: tb/tb_dccm_arb.sv
// Scoreboard bench for dccm_arb: read responses are queued when granted
// and compared when the DUT returns them one cycle later.
module tb_dccm_arb;

    typedef struct {
        logic        v;
        logic        we;
        logic [31:0] addr;
        logic [31:0] wdata;
    } req_t;

    typedef struct {
        logic        own;   // 1 = DMA
        logic [31:0] data;
    } rsp_t;

    localparam int G_NONE = 0, G_LSU = 1, G_DMA = 2;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        lsu_req_valid, lsu_req_ready, lsu_req_we;
    logic [31:0] lsu_req_addr, lsu_req_wdata;
    logic        lsu_rsp_valid;
    logic [31:0] lsu_rsp_rdata;
    logic        dma_req_valid, dma_req_ready, dma_req_we;
    logic [31:0] dma_req_addr, dma_req_wdata;
    logic        dma_rsp_valid;
    logic [31:0] dma_rsp_rdata;
    logic        dccm_wren, dccm_rden;
    logic [31:0] dccm_wr_addr, dccm_wr_data;
    logic [31:0] dccm_rd_data = 32'h0;

    int   n_chk = 0;
    int   n_bad = 0;
    rsp_t sb_q[$];

    dccm_arb #(.STARVE_MAX(4)) dut (
        .clk(clk), .rst_n(rst_n),
        .lsu_req_valid(lsu_req_valid), .lsu_req_ready(lsu_req_ready),
        .lsu_req_we(lsu_req_we), .lsu_req_addr(lsu_req_addr),
        .lsu_req_wdata(lsu_req_wdata), .lsu_rsp_valid(lsu_rsp_valid),
        .lsu_rsp_rdata(lsu_rsp_rdata),
        .dma_req_valid(dma_req_valid), .dma_req_ready(dma_req_ready),
        .dma_req_we(dma_req_we), .dma_req_addr(dma_req_addr),
        .dma_req_wdata(dma_req_wdata), .dma_rsp_valid(dma_rsp_valid),
        .dma_rsp_rdata(dma_rsp_rdata),
        .dccm_wren(dccm_wren), .dccm_rden(dccm_rden),
        .dccm_wr_addr(dccm_wr_addr), .dccm_wr_data(dccm_wr_data),
        .dccm_rd_data(dccm_rd_data)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] mem_f(input logic [31:0] a);
        return (a == 32'h100) ? 32'hDEADBEEF : {a[15:0], ~a[15:0]};
    endfunction

    // DCCM model: registered read, junk when not reading so ungated rdata shows up.
    always @(posedge clk)
        dccm_rd_data <= dccm_rden ? mem_f(dccm_wr_addr) : 32'hBAD0_BAD0;

    function automatic req_t mk(input logic v, input logic we,
                                input logic [31:0] a, input logic [31:0] d);
        req_t r;
        r.v = v; r.we = we; r.addr = a; r.wdata = d;
        return r;
    endfunction

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", tag, act, exp);
        end
    endtask

    // One cycle: drive, check at negedge, advance past posedge.
    task automatic step(input req_t l, input req_t d, input logic rst, input int g);
        req_t gr;
        rsp_t e;
        lsu_req_valid = l.v; lsu_req_we = l.we; lsu_req_addr = l.addr; lsu_req_wdata = l.wdata;
        dma_req_valid = d.v; dma_req_we = d.we; dma_req_addr = d.addr; dma_req_wdata = d.wdata;
        rst_n = rst;
        @(negedge clk);
        gr = (g == G_LSU) ? l : (g == G_DMA) ? d : mk(1'b0, 1'b0, 32'h0, 32'h0);
        chk("lsu_ready", 32'(lsu_req_ready), 32'(g == G_LSU));
        chk("dma_ready", 32'(dma_req_ready), 32'(g == G_DMA));
        chk("wren",  32'(dccm_wren), 32'(gr.v &&  gr.we));
        chk("rden",  32'(dccm_rden), 32'(gr.v && !gr.we));
        chk("addr",  dccm_wr_addr, gr.addr);
        chk("wdata", dccm_wr_data, gr.wdata);
        if (!rst) sb_q.delete();
        if (sb_q.size() != 0) begin
            e = sb_q.pop_front();
            chk("lsu_rsp_v", 32'(lsu_rsp_valid), 32'(!e.own));
            chk("dma_rsp_v", 32'(dma_rsp_valid), 32'(e.own));
            chk("lsu_rsp_d", lsu_rsp_rdata, e.own ? 32'h0 : e.data);
            chk("dma_rsp_d", dma_rsp_rdata, e.own ? e.data : 32'h0);
        end else begin
            chk("lsu_rsp_v", 32'(lsu_rsp_valid), 32'h0);
            chk("dma_rsp_v", 32'(dma_rsp_valid), 32'h0);
            chk("lsu_rsp_d", lsu_rsp_rdata, 32'h0);
            chk("dma_rsp_d", dma_rsp_rdata, 32'h0);
        end
        if (gr.v && !gr.we) begin
            e.own  = (g == G_DMA);
            e.data = mem_f(gr.addr);
            sb_q.push_back(e);
        end
        @(posedge clk);
        #1;
    endtask

    initial begin
        req_t idle, l, d;
        int   g;
        idle = mk(1'b0, 1'b0, 32'h0, 32'h0);
        rst_n = 1'b0;
        lsu_req_valid = 1'b0; lsu_req_we = 1'b0; lsu_req_addr = '0; lsu_req_wdata = '0;
        dma_req_valid = 1'b0; dma_req_we = 1'b0; dma_req_addr = '0; dma_req_wdata = '0;
        @(posedge clk);
        #1;

        // Reset: requests present but everything held at 0.
        step(mk(1, 0, 32'h40, 32'h0), mk(1, 1, 32'h44, 32'h55), 1'b0, G_NONE);
        step(mk(1, 0, 32'h40, 32'h0), idle, 1'b0, G_NONE);
        step(idle, idle, 1'b1, G_NONE);

        // LSU read of 0x100, response DEADBEEF next cycle.
        step(mk(1, 0, 32'h100, 32'h0), idle, 1'b1, G_LSU);
        step(idle, idle, 1'b1, G_NONE);

        // LSU write + DMA read together, then DMA alone, then its response.
        step(mk(1, 1, 32'h200, 32'h12345678), mk(1, 0, 32'h300, 32'h0), 1'b1, G_LSU);
        step(idle, mk(1, 0, 32'h300, 32'h0), 1'b1, G_DMA);
        step(idle, idle, 1'b1, G_NONE);

        // DMA write alone: no response.
        step(idle, mk(1, 1, 32'h380, 32'hCAFEF00D), 1'b1, G_DMA);
        step(idle, idle, 1'b1, G_NONE);

        // Alternating back-to-back reads, responses with no bubbles.
        for (int i = 0; i < 6; i++) begin
            if (i % 2 == 0) step(mk(1, 0, 32'h1000 + 32'(i * 4), 32'h0), idle, 1'b1, G_LSU);
            else            step(idle, mk(1, 0, 32'h2000 + 32'(i * 4), 32'h0), 1'b1, G_DMA);
        end
        step(idle, idle, 1'b1, G_NONE);

        // Both valid continuously: starvation override or strict priority.
        d = mk(1, 0, 32'h3000, 32'h0);
        for (int i = 0; i < 10; i++) begin
            l = mk(1, 0, 32'h4000 + 32'(i * 4), 32'h0);
`ifdef DCCM_ARB_STARVE_EN
            g = (i % 5 == 4) ? G_DMA : G_LSU;
`else
            g = G_LSU;
`endif
            if (g == G_DMA) d.addr = d.addr;  // DMA held stable until granted
            step(l, d, 1'b1, g);
            if (g == G_DMA) d.addr = d.addr + 32'h10;
        end
        step(idle, idle, 1'b1, G_NONE);

        // Reset the cycle after an LSU read grant: response must be dropped.
        step(mk(1, 0, 32'h500, 32'h0), idle, 1'b1, G_LSU);
        step(idle, idle, 1'b0, G_NONE);
        step(idle, idle, 1'b1, G_NONE);
        // Counter restarts from 0 after reset.
        d = mk(1, 0, 32'h600, 32'h0);
        for (int i = 0; i < 5; i++) begin
`ifdef DCCM_ARB_STARVE_EN
            g = (i == 4) ? G_DMA : G_LSU;
`else
            g = G_LSU;
`endif
            step(mk(1, 1, 32'h700 + 32'(i * 4), 32'(i)), d, 1'b1, g);
        end
        step(idle, idle, 1'b1, G_NONE);

        $display("test done: total=%0d bad=%0d", n_chk, n_bad);
        $finish;
    end

endmodule

// File: doc/dccm_arb.md
DCCM_ARB -- requirements
Module: dccm_arb

Interface
REQ-001 Parameter STARVE_MAX, default 4, consecutive DMA-stall cycles after which DMA wins arbitration; legal range 1..15.
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 rst_n  input  1  reset, synchronous, active-low.
REQ-004 lsu_req_valid  input  1  LSU access request.
REQ-005 lsu_req_ready  output  1  LSU request accepted this cycle.
REQ-006 lsu_req_we  input  1  1 = write, 0 = read.
REQ-007 lsu_req_addr  input  32  LSU byte address.
REQ-008 lsu_req_wdata  input  32  LSU write data.
REQ-009 lsu_rsp_valid  output  1  LSU read data valid.
REQ-010 lsu_rsp_rdata  output  32  LSU read data.
REQ-011 dma_req_valid, dma_req_ready, dma_req_we, dma_req_addr, dma_req_wdata, dma_rsp_valid, dma_rsp_rdata: same directions, widths and meanings as the LSU set, for the DMA port.
REQ-012 dccm_wren  output  1  DCCM write strobe.
REQ-013 dccm_rden  output  1  DCCM read strobe.
REQ-014 dccm_wr_addr  output  32  DCCM address, used for both reads and writes.
REQ-015 dccm_wr_data  output  32  DCCM write data.
REQ-016 dccm_rd_data  input  32  DCCM read data, valid one cycle after dccm_rden.

Function
REQ-017 The block SHALL issue at most one DCCM access per cycle, and grant it to exactly one requester.
REQ-018 Grant is combinational from the current-cycle valids. LSU wins if lsu_req_valid is high, unless the starvation override (REQ-020) is active. Otherwise DMA wins if dma_req_valid is high.
REQ-019 The granted requester's ready SHALL be high in the same cycle. The other ready SHALL be low. The request transfers on valid && ready.
REQ-020 Starvation counter (4 bits):
  - increments each cycle dma_req_valid is high and DMA is not granted;
  - clears when DMA is granted or dma_req_valid is low;
  - saturates at STARVE_MAX.
  - When the counter equals STARVE_MAX and dma_req_valid is high, DMA SHALL be granted over LSU.
REQ-021 On grant, dccm_wren = granted we and dccm_rden = !granted we. dccm_wr_addr and dccm_wr_data SHALL carry the granted requester's addr and wdata.
REQ-022 With no grant, dccm_wren = dccm_rden = 0. dccm_wr_addr and dccm_wr_data are 0.
REQ-023 A read granted in cycle N SHALL produce rsp_valid = 1 for that requester only in cycle N+1. rsp_rdata = dccm_rd_data in that cycle. The owner is held in a 1-bit registered tag plus a pending flag.
REQ-024 Writes SHALL produce no response.
REQ-025 rsp_rdata of the non-owner, and of both ports when no response is pending, SHALL be 0.
REQ-026 Back-to-back reads, from the same or alternating requesters, SHALL sustain one access per cycle with no bubbles.
REQ-027 A requester SHALL hold valid, we, addr and wdata stable until ready. The block does not check this.
REQ-028 Simultaneous response delivery (cycle N+1) and new grant (cycle N+1) SHALL both occur. The pending flag and tag update from the new grant.

Reset
REQ-029 While rst_n is low at a clock edge, the block SHALL clear the pending flag, the tag and the starvation counter.
REQ-030 During reset, lsu_rsp_valid and dma_rsp_valid SHALL be 0.
REQ-031 A read granted in the cycle rst_n is sampled low SHALL produce no response.
REQ-032 Combinational outputs (ready, dccm strobes) follow REQ-018..022 and SHALL be forced to 0 while rst_n is low.

Configuration
REQ-033 Macro DCCM_ARB_STARVE_EN: when defined, the starvation counter and override of REQ-020 SHALL be compiled in.
REQ-034 When DCCM_ARB_STARVE_EN is undefined, arbitration SHALL be strict LSU priority, and the counter SHALL not exist.

Verification
REQ-035 LSU read of 0x100 alone, then dccm_rd_data = 0xDEADBEEF -> dccm_rden = 1 and addr = 0x100 in cycle N; lsu_rsp_valid = 1 with 0xDEADBEEF in N+1; dma_rsp_valid = 0.
REQ-036 LSU write (0x200, 0x12345678) and DMA read (0x300) in the same cycle -> LSU granted with dccm_wren = 1; DMA granted the next cycle; DMA response one cycle later.
REQ-037 STARVE_MAX = 4, LSU and DMA both valid continuously, macro defined:
  - LSU granted 4 cycles;
  - DMA granted in the 5th cycle;
  - counter clears.
  - With the macro undefined, DMA is never granted.
REQ-038 Alternating LSU/DMA reads on 6 consecutive cycles -> 6 responses in 6 consecutive cycles, each to the correct owner, with matching data.
REQ-039 rst_n low in the cycle after an LSU read grant -> lsu_rsp_valid stays 0; counter and pending flag read 0 after reset.
